// File: rtl/sccb_target.sv
// SCCB target engine: decodes SIOC/SIOD traffic for an OV5642-style register map
// (7-bit ID, 16-bit address, 8-bit data) onto a simple register-port handshake.
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h3C
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sioc,
  input  logic        i_siod_in,
  output logic        o_siod_out,
  output logic        o_siod_oe,
  output logic [15:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  output logic        o_reg_we,
  output logic        o_reg_re,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SYNC_W = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_ADDR_HI,
    S_ADDR_HI_ACK,
    S_ADDR_LO,
    S_ADDR_LO_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_e;

  logic [SYNC_W-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_W-1:0] siod_sync_q, siod_sync_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              sda_q, sda_d;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              re_dly_q, re_dly_d;
  logic              reload_q, reload_d;

  logic              siod_oe_q, siod_oe_d;
  logic              siod_out_q, siod_out_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] rx_byte;

  // State register; synchronizers reset to the idle-bus level so reset creates no events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      sda_q       <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      re_dly_q    <= 1'b0;
      reload_q    <= 1'b0;
      siod_oe_q   <= 1'b0;
      siod_out_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      sda_q       <= sda_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      re_dly_q    <= re_dly_d;
      reload_q    <= reload_d;
      siod_oe_q   <= siod_oe_d;
      siod_out_q  <= siod_out_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  // Pin synchronization and registered bus-event detection from stages 2 and 3.
  always_comb begin
    sioc_sync_d = {sioc_sync_q[SYNC_W-2:0], i_sioc};
    siod_sync_d = {siod_sync_q[SYNC_W-2:0], i_siod_in};
    rise_d      = sioc_sync_q[1] & ~sioc_sync_q[2];
    fall_d      = ~sioc_sync_q[1] & sioc_sync_q[2];
    start_d     = sioc_sync_q[1] & sioc_sync_q[2] & ~siod_sync_q[1] & siod_sync_q[2];
    stop_d      = sioc_sync_q[1] & sioc_sync_q[2] & siod_sync_q[1] & ~siod_sync_q[2];
    sda_d       = siod_sync_q[1];
  end

  assign rx_byte = {shift_q[DATA_W-2:0], sda_q};

  // Protocol FSM: bits sampled on SIOC rise, drive changes on SIOC fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reload_d    = reload_q;
    siod_oe_d   = siod_oe_q;
    siod_out_d  = siod_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    re_dly_d    = reg_re_q;
    rdata_d     = re_dly_q ? i_reg_rdata : rdata_q;

    if (start_q) begin
      state_d    = S_ID;
      bit_cnt_d  = '0;
      reload_d   = 1'b0;
      siod_oe_d  = 1'b0;
      siod_out_d = 1'b0;
      busy_d     = 1'b1;
    end else if (stop_q) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      reload_d   = 1'b0;
      siod_oe_d  = 1'b0;
      siod_out_d = 1'b0;
      busy_d     = 1'b0;
    end else if (rise_q) begin
      case (state_q)
        S_ID, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            case (state_q)
              S_ID: begin
                if (rx_byte[DATA_W-1:1] == DEV_ID) begin
                  state_d  = S_ID_ACK;
                  reg_re_d = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                end
              end
              S_ADDR_HI: begin
                reg_addr_d[ADDR_W-1:DATA_W] = rx_byte;
                state_d = S_ADDR_HI_ACK;
              end
              S_ADDR_LO: begin
                reg_addr_d[DATA_W-1:0] = rx_byte;
                state_d = S_ADDR_LO_ACK;
              end
              default: begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
                state_d     = S_WDATA_ACK;
              end
            endcase
          end
        end
        S_RDATA: begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = S_RDATA_ACK;
        end
        S_RDATA_ACK: begin
          if (!sda_q) begin
            reg_addr_d = reg_addr_q + ADDR_W'(1);
            reg_re_d   = 1'b1;
            reload_d   = 1'b1;
          end else begin
            state_d = S_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (fall_q) begin
      case (state_q)
        // First fall in an ACK state starts the low drive; the second ends the ACK bit.
        S_ID_ACK, S_ADDR_HI_ACK, S_ADDR_LO_ACK, S_WDATA_ACK: begin
          if (!siod_oe_q) begin
            siod_oe_d  = 1'b1;
            siod_out_d = 1'b0;
          end else begin
            siod_oe_d  = 1'b0;
            siod_out_d = 1'b0;
            bit_cnt_d  = '0;
            case (state_q)
              S_ID_ACK: begin
                if (shift_q[0]) begin
                  shift_d    = rdata_q;
                  siod_oe_d  = 1'b1;
                  siod_out_d = rdata_q[DATA_W-1];
                  state_d    = S_RDATA;
                end else begin
                  state_d = S_ADDR_HI;
                end
              end
              S_ADDR_HI_ACK: state_d = S_ADDR_LO;
              S_ADDR_LO_ACK: state_d = S_WDATA;
              default: begin
                reg_addr_d = reg_addr_q + ADDR_W'(1);
                state_d    = S_WDATA;
              end
            endcase
          end
        end
        S_RDATA: begin
          shift_d    = {shift_q[DATA_W-2:0], 1'b0};
          siod_out_d = shift_q[DATA_W-2];
        end
        S_RDATA_ACK: begin
          if (siod_oe_q) begin
            siod_oe_d  = 1'b0;
            siod_out_d = 1'b0;
          end else if (reload_q) begin
            reload_d   = 1'b0;
            shift_d    = rdata_q;
            siod_oe_d  = 1'b1;
            siod_out_d = rdata_q[DATA_W-1];
            bit_cnt_d  = '0;
            state_d    = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_siod_out  = siod_out_q;
  assign o_siod_oe   = siod_oe_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_reg_we    = reg_we_q;
  assign o_reg_re    = reg_re_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB target (slave) engine that answers the SIOC/SIOD traffic produced by the team's SCCB master. It presents the OV5642 register protocol: 7-bit device ID, 16-bit register address and 8-bit data. Decoded accesses go to a simple register-port handshake. It is used as the camera stand-in for master loopback benches and board bring-up, and as the front end of the on-FPGA register mirror.

## Interface
- DEV_ID, 7'h3C, 7-bit device address this target answers to (write ID byte 0x78, read ID byte 0x79).
- i_clk  in  1  system clock, 100 MHz; must be at least 20x the SIOC rate.
- i_rst  in  1  reset, synchronous, active-high.
- i_sioc  in  1  SIOC from the master, asynchronous.
- i_siod_in  in  1  SIOD pad input, asynchronous.
- o_siod_out  out  1  SIOD drive value.
- o_siod_oe  out  1  1 = target drives SIOD with o_siod_out; 0 = released.
- o_reg_addr  out  16  current register address.
- o_reg_wdata  out  8  write data, valid while o_reg_we = 1.
- o_reg_we  out  1  1-cycle write strobe.
- o_reg_re  out  1  1-cycle read request.
- i_reg_rdata  in  8  read data, sampled exactly 2 i_clk cycles after o_reg_re.
- o_busy  out  1  high from detected START until detected STOP.

## Operation
- i_sioc and i_siod_in each pass through a 2-flop synchronizer, then a third history flop. Edges and conditions are decoded from stages 2 and 3.
- START: SIOD falls while SIOC is high. STOP: SIOD rises while SIOC is high.
- START in any state is a repeated start: go to ID and clear the bit counter.
- STOP in any state: go to IDLE and release SIOD.
- A 3-bit bit counter and an 8-bit shift register are used. Bits are sampled MSB first on the SIOC rising edge. Drive changes take effect on the SIOC falling edge.
- States:
  - IDLE: wait for START.
  - ID: shift in 8 bits.
    - If ID[7:1] == DEV_ID, go to ID_ACK.
    - Otherwise go to IGNORE.
    - If bit0 = 1, pulse o_reg_re at the rising edge that samples bit 0.
  - ID_ACK: drive 0 for the 9th bit.
    - Write ID: go to ADDR_HI.
    - Read ID: go to RDATA. On the ACK-ending falling edge, load the shift register from the i_reg_rdata captured earlier.
  - ADDR_HI, ADDR_LO: shift into o_reg_addr[15:8] and o_reg_addr[7:0]. Each byte is followed by ADDR_HI_ACK / ADDR_LO_ACK, which drive 0.
  - WDATA: on the rising edge that samples bit 0, set o_reg_wdata and pulse o_reg_we for 1 cycle with the current o_reg_addr. Then go to WDATA_ACK (drive 0).
  - WDATA_ACK: at the ACK-ending falling edge, increment o_reg_addr (wraps 0xFFFF -> 0x0000) and return to WDATA.
  - RDATA: drive the shift register MSB first, 8 bits. Then release SIOD and go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit.
    - 0 (ACK): increment the address, pulse o_reg_re, reload, return to RDATA.
    - 1 (NA): go to IGNORE.
  - IGNORE: never drive; wait for START/STOP.
- ACK is a don't-care in SCCB, but this target always drives it low. An address mismatch is never acknowledged.
- o_reg_addr persists across transactions, so a 2-phase read (write ID + address, STOP, then read ID) reads the last-written address.

## Timing
- Reset values: o_siod_oe 0, o_siod_out 0, o_reg_addr 0x0000, o_reg_wdata 0x00, o_reg_we 0, o_reg_re 0, o_busy 0. State is IDLE and the bit counter is 0.
- Latency from SIOC pin edge to registered output change (o_siod_oe, o_siod_out, strobes) is exactly 4 i_clk cycles: 2 sync, 1 detect, 1 output register.
- Latency from START/STOP condition at the pins to the o_busy change is 4 i_clk cycles.
- Master data changes mid-SIOC-low. The 4-cycle target release is therefore well before master drive; no overlap at 100 kHz.
- START and a SIOC edge detected in the same cycle: START wins.
- Reset mid-transaction: outputs return to reset values on the next cycle, and SIOD is released. Subsequent bits are ignored until a new START.
- o_reg_we and o_reg_re are never asserted in the same cycle.

## Test plan
- Write 0x78, 0x30, 0x08, 0x80, STOP -> exactly one o_reg_we with addr 0x3008 and wdata 0x80. o_siod_oe=1 with out=0 during each of the 4 ninth bits. o_busy falls 4 cycles after STOP.
- 2-phase read: 0x78, 0x30, 0x0A, STOP; then START, 0x79, i_reg_rdata=0x56, master NA, STOP -> o_reg_re with addr 0x300A. SIOD carries 0,1,0,1,0,1,1,0. oe=0 during the 9th bit; state returns to IDLE.
- Mismatched ID 0x42 followed by 3 bytes -> o_siod_oe never 1, no we/re strobes.
- Burst write 0x78, 0xFF, 0xFF, 0x11, 0x22 -> we at 0xFFFF (0x11), then 0x0000 (0x22) (wrap).
- Repeated START after ADDR_HI, then a full write to 0x1234 -> only the 0x1234 write strobes. Assert i_rst mid-RDATA -> oe drops next cycle, and nothing is driven until a new START.
- Loopback against the team SCCB master at SIOC_FREQ 100000 -> write then read of 0x3818 returns the written byte on o_rx_data.
